// File: rtl/alu_param_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_param_pipe
//  Purpose  : N-bit integer ALU used as the execute stage. Add, subtract,
//             logic, barrel shifts, multiply and divide, with Z/C/Nf/V flags.
//             One registered output stage, so latency is one cycle. A valid
//             strobe travels with the data.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_param_pipe #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   opcode,
  output logic [N-1:0] result,
  output logic         Z,
  output logic         C,
  output logic         Nf,
  output logic         V,
  output logic         out_valid
);

  // Width of the shift-amount field, derived from N and not overridden.
  localparam int SW = $clog2(N);

  typedef logic [N-1:0] word_t;

  localparam word_t N_VEC = word_t'(N);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;
  localparam logic [3:0] OP_ASR = 4'b1010;

  // The adder and subtractor are one bit wider than N. The extra top bit is the carry or borrow.
  logic [N:0]     add_full;
  logic [N:0]     sub_full;
  logic [2*N-1:0] prod;
  word_t          quot;
  logic           shift_big;

  assign add_full  = {1'b0, A} + {1'b0, B};
  assign sub_full  = {1'b0, A} - {1'b0, B};
  assign prod      = {{N{1'b0}}, A} * {{N{1'b0}}, B};
  assign quot      = (B == '0) ? '1 : (A / B);
  assign shift_big = (B >= N_VEC);

  // The shifters work on N+1 bit vectors. The extra bit catches the bit that
  // leaves last. SHL carries that bit in position N. SHR and ASR carry it in position 0.
  logic [N:0] shl_v;
  logic [N:0] shr_v;
  logic [N:0] asr_v;

  // Barrel shifter with log2(N) stages. Stage i shifts by 2**i when B[i] is set.
  always_comb begin
    shl_v = {1'b0, A};
    shr_v = {A, 1'b0};
    asr_v = {A, 1'b0};
    for (int i = 0; i < SW; i++) begin
      if (B[i]) begin
        shl_v = shl_v << (1 << i);
        shr_v = shr_v >> (1 << i);
        asr_v = $unsigned($signed(asr_v) >>> (1 << i));
      end
    end
  end

  word_t nxt_result;
  logic  nxt_c;
  logic  nxt_v;

  // Select the result and the C/V flags for the current opcode.
  always_comb begin
    nxt_result = '0;
    nxt_c      = 1'b0;
    nxt_v      = 1'b0;
    case (opcode)
      OP_ADD: begin
        nxt_result = add_full[N-1:0];
        nxt_c      = add_full[N];
        nxt_v      = (A[N-1] == B[N-1]) && (add_full[N-1] != A[N-1]);
      end
      OP_SUB: begin
        nxt_result = sub_full[N-1:0];
        nxt_c      = sub_full[N];
        nxt_v      = (A[N-1] != B[N-1]) && (sub_full[N-1] != A[N-1]);
      end
      OP_AND: nxt_result = A & B;
      OP_OR:  nxt_result = A | B;
      OP_XOR: nxt_result = A ^ B;
      OP_NOT: nxt_result = ~A;
      OP_SHL: begin
        nxt_result = shift_big ? '0 : shl_v[N-1:0];
        nxt_c      = shift_big ? 1'b0 : shl_v[N];
      end
      OP_SHR: begin
        nxt_result = shift_big ? '0 : shr_v[N:1];
        nxt_c      = shift_big ? 1'b0 : shr_v[0];
      end
      OP_ASR: begin
        nxt_result = shift_big ? {N{A[N-1]}} : asr_v[N:1];
        nxt_c      = shift_big ? A[N-1] : asr_v[0];
      end
      OP_MUL: begin
        nxt_result = prod[N-1:0];
        nxt_c      = |prod[2*N-1:N];
        nxt_v      = |prod[2*N-1:N];
      end
      OP_DIV: begin
        nxt_result = quot;
        nxt_v      = (B == '0);
      end
      default: begin
        nxt_result = '0;
      end
    endcase
  end

  // Output register. When in_valid is low, result and flags hold their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      Z         <= 1'b0;
      C         <= 1'b0;
      Nf        <= 1'b0;
      V         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= nxt_result;
        Z      <= (nxt_result == '0);
        C      <= nxt_c;
        Nf     <= nxt_result[N-1];
        V      <= nxt_v;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_param_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_alu_param_pipe
//  Purpose  : Scoreboard bench for alu_param_pipe with N=16. The stimulus
//             process pushes the expected results. The monitor process pops
//             and compares them whenever out_valid is high.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_param_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [3:0]  opcode = '0;
  logic [15:0] result;
  logic        Z, C, Nf, V, out_valid;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic        z, c, n, v;
    int          cyc;
  } exp_t;

  exp_t scoreboard[$];

  alu_param_pipe #(.N(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B),
    .opcode(opcode), .result(result), .Z(Z), .C(C), .Nf(Nf), .V(V),
    .out_valid(out_valid)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Monitor: pops and compares whenever out_valid is high, and checks the hold behaviour otherwise
  initial begin
    exp_t        e;
    logic [19:0] prev;
    prev = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        prev = '0;
      end else begin
        checks++;
        if (out_valid) begin
          if (scoreboard.size() == 0) begin
            failures++;
            $display("FAIL unexpected_out_valid: got result=%h with nothing expected", result);
          end else begin
            e = scoreboard.pop_front();
            if ({result, Z, C, Nf, V} !== {e.res, e.z, e.c, e.n, e.v} || cyc != e.cyc)
            begin
              failures++;
              $display("FAIL %s: got res=%h Z=%b C=%b Nf=%b V=%b cyc=%0d, expected res=%h Z=%b C=%b Nf=%b V=%b cyc=%0d",
                       e.name, result, Z, C, Nf, V, cyc, e.res, e.z, e.c, e.n, e.v, e.cyc);
            end
          end
        end else if ({result, Z, C, Nf, V} !== prev) begin
          failures++;
          $display("FAIL hold_when_idle: got %h, expected %h", {result, Z, C, Nf, V}, prev);
        end
        prev = {result, Z, C, Nf, V};
      end
    end
  end

  task automatic issue(input string nm, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] r,
                       input logic z, input logic c, input logic n, input logic v);
    exp_t e;
    @(negedge clk);
    opcode   = op;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    e.name = nm; e.res = r; e.z = z; e.c = c; e.n = n; e.v = v;
    e.cyc  = cyc + 1;
    scoreboard.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Reference model for the random ALU ops. It uses integer arithmetic to get carry and overflow.
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic c, output logic v);
    int sa, sbv, s;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin
        r = a + b;
        c = (int'(a) + int'(b)) > 65535;
        s = sa + sbv;
        v = (s > 32767) || (s < -32768);
      end
      4'd1: begin
        r = a - b;
        c = (a < b);
        s = sa - sbv;
        v = (s > 32767) || (s < -32768);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      default: r = a ^ b;
    endcase
  endfunction

  initial begin
    logic [15:0] r;
    logic        c, v;
    logic [3:0]  op;
    logic [15:0] a, b;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({result, Z, C, Nf, V, out_valid} !== 21'd0) begin
      failures++;
      $display("FAIL reset_state: got %h, expected 0", {result, Z, C, Nf, V, out_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Basic ops with A=10, B=5
    issue("add_basic", 4'b0000, 16'd10, 16'd5, 16'h000F, 0, 0, 0, 0);
    issue("sub_basic", 4'b0001, 16'd10, 16'd5, 16'h0005, 0, 0, 0, 0);
    issue("and_basic", 4'b0010, 16'd10, 16'd5, 16'h0000, 1, 0, 0, 0);
    issue("or_basic",  4'b0011, 16'd10, 16'd5, 16'h000F, 0, 0, 0, 0);
    issue("xor_basic", 4'b0100, 16'd10, 16'd5, 16'h000F, 0, 0, 0, 0);
    issue("not_basic", 4'b0101, 16'd10, 16'd5, 16'hFFF5, 0, 0, 1, 0);
    // Flag cases
    issue("add_carry", 4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0, 0);
    issue("add_ovf",   4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 0, 0, 1, 1);
    issue("sub_borrow",4'b0001, 16'd5, 16'd10, 16'hFFFB, 0, 1, 1, 0);
    issue("sub_zero",  4'b0001, 16'd10, 16'd10, 16'h0000, 1, 0, 0, 0);
    issue("sub_ovf",   4'b0001, 16'h8000, 16'h0001, 16'h7FFF, 0, 0, 0, 1);
    // Shifts of B38F
    issue("shl_3",     4'b0110, 16'hB38F, 16'd3,  16'h9C78, 0, 1, 1, 0);
    issue("shr_2",     4'b0111, 16'hB38F, 16'd2,  16'h2CE3, 0, 1, 0, 0);
    issue("asr_2",     4'b1010, 16'hB38F, 16'd2,  16'hECE3, 0, 1, 1, 0);
    issue("shl_16",    4'b0110, 16'hB38F, 16'd16, 16'h0000, 1, 0, 0, 0);
    issue("asr_20",    4'b1010, 16'hB38F, 16'd20, 16'hFFFF, 0, 1, 1, 0);
    issue("shr_0",     4'b0111, 16'hB38F, 16'd0,  16'hB38F, 0, 0, 1, 0);
    issue("shr_15",    4'b0111, 16'hB38F, 16'd15, 16'h0001, 0, 0, 0, 0);
    issue("shl_15",    4'b0110, 16'hB38F, 16'd15, 16'h8000, 0, 1, 1, 0);
    issue("asr_15",    4'b1010, 16'hB38F, 16'd15, 16'hFFFF, 0, 0, 1, 0);
    issue("shr_big",   4'b0111, 16'hB38F, 16'h0100, 16'h0000, 1, 0, 0, 0);
    // MUL / DIV / reserved
    issue("mul_ovf",   4'b1000, 16'h0100, 16'h0100, 16'h0000, 1, 1, 0, 1);
    issue("mul_small", 4'b1000, 16'h0007, 16'h0003, 16'h0015, 0, 0, 0, 0);
    issue("div_basic", 4'b1001, 16'h0064, 16'h0007, 16'h000E, 0, 0, 0, 0);
    issue("div_zero",  4'b1001, 16'h1234, 16'h0000, 16'hFFFF, 0, 0, 1, 1);
    issue("reserved",  4'b1100, 16'h1234, 16'h5678, 16'h0000, 1, 0, 0, 0);

    // Drop in_valid for one cycle. The monitor checks that the outputs hold.
    issue("pre_gap",   4'b0011, 16'hA000, 16'h0005, 16'hA005, 0, 0, 1, 0);
    idle();
    issue("post_gap",  4'b0000, 16'h0001, 16'h0002, 16'h0003, 0, 0, 0, 0);

    // Assert reset asynchronously while a result is showing and another op is in flight
    issue("pre_rst",   4'b0000, 16'h1234, 16'h1111, 16'h2345, 0, 0, 0, 0);
    issue("discarded", 4'b0000, 16'h0001, 16'h0001, 16'h0002, 0, 0, 0, 0);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if ({result, Z, C, Nf, V, out_valid} !== 21'd0) begin
      failures++;
      $display("FAIL async_reset: got %h, expected 0", {result, Z, C, Nf, V, out_valid});
    end
    scoreboard.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Random ADD/SUB/AND/OR/XOR ops checked against the reference model
    for (int i = 0; i < 20; i++) begin
      op = 4'($urandom_range(0, 4));
      a  = 16'($urandom);
      b  = 16'($urandom);
      model(op, a, b, r, c, v);
      issue($sformatf("rand_%0d", i), op, a, b, r, (r == 16'h0), c, r[15], v);
    end
    idle();
    repeat (3) @(negedge clk);

    checks++;
    if (scoreboard.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d outstanding results, expected 0", scoreboard.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
